conv1_layer_ctrl: RTL and testbench

//  Sequencer for the Convolution 1 layer of the digit-recognition datapath. On start it

---
 rtl/conv1_layer_ctrl_if.sv | 27 ++
 rtl/conv1_layer_ctrl.sv | 133 +++++++++++++
 tb/tb_conv1_layer_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/conv1_layer_ctrl_if.sv
// Control/address bundle between the conv1 sequencer and its host, datapath and output memory.
// The master side is the sequencer; the slave side is the host/datapath.
interface conv1_layer_ctrl_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic              stall;
  logic              w_load_en;
  logic [4:0]        w_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic              busy;
  logic              done;

  modport master (
    input  start, stall,
    output w_load_en, w_addr, rd_en, rd_addr, wr_en, wr_addr0, wr_addr1, busy, done
  );

  modport slave (
    output start, stall,
    input  w_load_en, w_addr, rd_en, rd_addr, wr_en, wr_addr0, wr_addr1, busy, done
  );
endinterface

// File: rtl/conv1_layer_ctrl.sv
// Conv1 layer sequencer: kernel load, input streaming, latency-aligned dual-bank writes.
// Optional CONV1_PERF_CNT_EN adds a cycle_cnt output counting the cycles of the last layer run.
module conv1_layer_ctrl #(
  parameter int OUT_WORDS = 576,
  parameter int PIPE_LAT  = 3,
  parameter int W_LOAD    = 25,
  parameter int ADDR_W    = 10
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef CONV1_PERF_CNT_EN
  output logic [15:0]              cycle_cnt,
`endif
  conv1_layer_ctrl_if.master       bus
);
  localparam int HALF = OUT_WORDS / 2;
  localparam logic [ADDR_W-1:0] HALF_A    = ADDR_W'(HALF);
  localparam logic [ADDR_W-1:0] HALF_LAST = ADDR_W'(HALF - 1);
  localparam logic [4:0]        W_LAST    = 5'(W_LOAD - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          w_addr_q, w_addr_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   wr_addr0_q, wr_addr0_d;
  logic [PIPE_LAT-1:0] pipe_q, pipe_d;
  logic                w_load_en, rd_en, wr_en, busy, done;
`ifdef CONV1_PERF_CNT_EN
  logic [15:0]         cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      w_addr_q   <= '0;
      rd_addr_q  <= '0;
      wr_addr0_q <= '0;
      pipe_q     <= '0;
`ifdef CONV1_PERF_CNT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      w_addr_q   <= w_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr0_q <= wr_addr0_d;
      pipe_q     <= pipe_d;
`ifdef CONV1_PERF_CNT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    w_addr_d   = w_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_addr0_d = wr_addr0_q;
    pipe_d     = pipe_q;
    w_load_en  = 1'b0;
    rd_en      = 1'b0;
    done       = 1'b0;
    busy       = (state_q == S_LOAD_W) || (state_q == S_RUN) || (state_q == S_DRAIN);
`ifdef CONV1_PERF_CNT_EN
    // Counts every cycle of the layer, stalled ones and the done cycle included.
    cnt_d      = (state_q != S_IDLE) ? cnt_q + 16'd1 : cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_LOAD_W;
          w_addr_d   = '0;
          rd_addr_d  = '0;
          wr_addr0_d = '0;
`ifdef CONV1_PERF_CNT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_LOAD_W: begin
        if (!bus.stall) begin
          w_load_en = 1'b1;
          if (w_addr_q == W_LAST) begin
            w_addr_d = '0;
            state_d  = S_RUN;
          end else begin
            w_addr_d = w_addr_q + 5'd1;
          end
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          rd_en = 1'b1;
          // Last read address is held so the host sees the final index.
          if (rd_addr_q == HALF_LAST) state_d = S_DRAIN;
          else                        rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // Valid pipe mirrors datapath latency; it freezes together with the datapath on stall.
    wr_en = pipe_q[PIPE_LAT-1] && !bus.stall;
    if (!bus.stall) begin
      pipe_d[0] = rd_en;
      for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end

    if (wr_en) begin
      if (wr_addr0_q == HALF_LAST) state_d = S_DONE;
      else                         wr_addr0_d = wr_addr0_q + ADDR_W'(1);
    end
  end

  assign bus.w_load_en = w_load_en;
  assign bus.w_addr    = w_addr_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr0  = wr_addr0_q;
  assign bus.wr_addr1  = wr_addr0_q + HALF_A;
  assign bus.busy      = busy;
  assign bus.done      = done;
`ifdef CONV1_PERF_CNT_EN
  assign cycle_cnt     = cnt_q;
`endif
endmodule

// File: tb/tb_conv1_layer_ctrl.sv
// Directed bench for conv1_layer_ctrl: reset, plain run, mid-run stall, ignored starts, abort.
// Cycle numbers count edges from the edge that accepts start (edge 0).
module tb_conv1_layer_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  conv1_layer_ctrl_if #(.ADDR_W(10)) bus ();
`ifdef CONV1_PERF_CNT_EN
  logic [15:0] cycle_cnt;
`endif

  conv1_layer_ctrl dut (
    .clk       (clk),
    .reset     (reset),
`ifdef CONV1_PERF_CNT_EN
    .cycle_cnt (cycle_cnt),
`endif
    .bus       (bus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_w_load_en"}, int'(bus.w_load_en), 0);
    check({pfx, "_w_addr"},    int'(bus.w_addr), 0);
    check({pfx, "_rd_en"},     int'(bus.rd_en), 0);
    check({pfx, "_rd_addr"},   int'(bus.rd_addr), 0);
    check({pfx, "_wr_en"},     int'(bus.wr_en), 0);
    check({pfx, "_wr_addr0"},  int'(bus.wr_addr0), 0);
    check({pfx, "_wr_addr1"},  int'(bus.wr_addr1), 288);
    check({pfx, "_busy"},      int'(bus.busy), 0);
    check({pfx, "_done"},      int'(bus.done), 0);
`ifdef CONV1_PERF_CNT_EN
    check({pfx, "_cycle_cnt"}, int'(cycle_cnt), 0);
`endif
  endtask

  // One layer run. Optional stall at rd_addr=100, start glitches, or reset abort at rd_addr=100.
  task automatic run_layer(input int tn, input int stall_len, input bit glitch, input bit abort);
    int c = 0, loads = 0, reads = 0, writes = 0;
    int first_rd = -1, first_wr = -1, last0 = -1, last1 = -1;
    int done_cnt = 0, done_cyc = 0, busy_cyc = 0, seq_err = 0, stall_err = 0;
    int stall_left = 0, frozen_rd = 0, frozen_w0 = 0, loads_after_done = 0;
    bit stalled_once = 1'b0;
    string p = $sformatf("t%0d", tn);

    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      c++;
      bus.stall = (stall_left > 0);
      bus.start = glitch && (c == 10 || c == 100 || c == 315 || c == 317);
      #1;
      if (bus.stall) begin
        if (bus.w_load_en || bus.rd_en || bus.wr_en) stall_err++;
        if (int'(bus.rd_addr) != frozen_rd || int'(bus.wr_addr0) != frozen_w0) stall_err++;
        stall_left--;
      end
      if (abort && bus.rd_en && bus.rd_addr == 10'd100) begin
        reset = 1'b1;
        #1;
        check_idle_outputs({p, "_abort"});
        bus.start = 1'b0;
        bus.stall = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        return;
      end
      if (bus.w_load_en) begin
        if (int'(bus.w_addr) != loads) seq_err++;
        if (done_cyc > 0) loads_after_done++;
        loads++;
      end
      if (bus.wr_en) begin
        if (int'(bus.wr_addr0) != writes || int'(bus.wr_addr1) != writes + 288) seq_err++;
        if (first_wr < 0) first_wr = c;
        last0 = int'(bus.wr_addr0);
        last1 = int'(bus.wr_addr1);
        writes++;
      end
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != reads) seq_err++;
        if (first_rd < 0) first_rd = c;
        reads++;
        if (stall_len > 0 && !stalled_once && bus.rd_addr == 10'd99) begin
          stalled_once = 1'b1;
          stall_left   = stall_len;
          frozen_rd    = 100;
          frozen_w0    = writes;
        end
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
        if (bus.busy) seq_err++;
      end
      if (done_cyc > 0 && c >= done_cyc + 5) break;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    check({p, "_w_loads"},      loads, 25);
    check({p, "_reads"},        reads, 288);
    check({p, "_writes"},       writes, 288);
    check({p, "_first_rd_cyc"}, first_rd, 26);
    check({p, "_first_wr_cyc"}, first_wr, 29);
    check({p, "_last_addr0"},   last0, 287);
    check({p, "_last_addr1"},   last1, 575);
    check({p, "_done_pulses"},  done_cnt, 1);
    check({p, "_done_cyc"},     done_cyc, 317 + stall_len);
    check({p, "_busy_cycles"},  busy_cyc, 316 + stall_len);
    check({p, "_addr_seq_err"}, seq_err, 0);
    check({p, "_stall_err"},    stall_err, 0);
    check({p, "_late_loads"},   loads_after_done, 0);
    check({p, "_hold_rd_addr"}, int'(bus.rd_addr), 287);
    check({p, "_hold_addr0"},   int'(bus.wr_addr0), 287);
    check({p, "_hold_addr1"},   int'(bus.wr_addr1), 575);
    check({p, "_idle_busy"},    int'(bus.busy), 0);
`ifdef CONV1_PERF_CNT_EN
    check({p, "_cycle_cnt"},    int'(cycle_cnt), 317 + stall_len);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("t1_reset");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check_idle_outputs("t1_idle");

    run_layer(2, 0, 1'b0, 1'b0);
    run_layer(3, 10, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    check("t3_hold_addr0_idle", int'(bus.wr_addr0), 287);
`ifdef CONV1_PERF_CNT_EN
    check("t6_cnt_holds", int'(cycle_cnt), 327);
`endif
    run_layer(4, 0, 1'b1, 1'b0);
    run_layer(5, 0, 1'b0, 1'b1);
    check_idle_outputs("t5_after_abort");
    run_layer(5, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
